// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared RV64 fetch/decode definitions: address width, bubble
//                instruction, major opcode values and the fetch FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_pkg;

   localparam int XLEN = 64;

   // addi x0, x0, 0 : architecturally harmless bubble
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_IMM  = 7'b0010011;
   localparam logic [6:0] OP_ST   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid_buf
//  Description : One-entry instruction/PC buffer that catches a fetch
//                response arriving while decode is stalled.
//  Ports       : clk, reset_n (sync, active-low)
//                load / clear      - capture in_pc/in_instr / drop entry
//                in_pc, in_instr   - data to capture
//                valid, pc, instr  - buffered entry
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_skid_buf #(
   parameter int          XLEN      = riscv_pkg::XLEN,
   parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            load,
   input  logic            clear,
   input  logic [XLEN-1:0] in_pc,
   input  logic [31:0]     in_instr,
   output logic            valid,
   output logic [XLEN-1:0] pc,
   output logic [31:0]     instr
);

   // clear wins over load: a redirect in the capture cycle discards the data
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid <= 1'b0;
         pc    <= '0;
         instr <= NOP_INSTR;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         pc    <= in_pc;
         instr <= in_instr;
      end
   end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : RV64 fetch stage. Holds the PC, issues one instruction
//                memory request at a time, registers the returned word with
//                its PC and presents the opcode to the control unit. Handles
//                downstream stall and redirect, discarding stale responses.
//  Ports       : clk, reset_n (sync, active-low)
//                imem_req_valid/addr/ready  - request handshake
//                imem_rsp_valid/data        - one response per accepted req
//                stall                      - hold IF/ID outputs
//                redirect_valid/pc          - control transfer target
//                if_valid/pc/instr/opcode   - IF/ID outputs
//                fetch_misalign             - only with FETCH_MISALIGN_TRAP_EN
//  Config      : FETCH_MISALIGN_TRAP_EN - a redirect to a non-word-aligned
//                target halts fetch and raises fetch_misalign until an
//                aligned redirect or reset. Without it the target's low two
//                bits are forced to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
   parameter int          XLEN      = riscv_pkg::XLEN,
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            reset_n,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [31:0]     if_instr,
   output logic [6:0]      if_opcode
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic            fetch_misalign
`endif
);

   import riscv_pkg::*;

   fetch_state_t    state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt;
   logic [XLEN-1:0] inflight_pc;       // address of the outstanding request
   logic            kill, kill_nxt;    // outstanding response is stale
   logic [XLEN-1:0] redirect_tgt;
   logic            stuck;             // fetch halted on misaligned target
   logic            req_fire;

   logic            load_mem, load_buf, bubble;
   logic            buf_load, buf_clear;
   logic            buf_valid;
   logic [XLEN-1:0] buf_pc;
   logic [31:0]     buf_instr;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misalign, misalign_nxt;
   logic redirect_bad;
   assign redirect_tgt   = redirect_pc;
   assign redirect_bad   = redirect_valid & (redirect_pc[1:0] != 2'b00);
   assign stuck          = misalign;
   assign fetch_misalign = misalign;
`else
   logic unused_low_bits;
   assign redirect_tgt    = {redirect_pc[XLEN-1:2], 2'b00};
   assign stuck           = 1'b0;
   assign unused_low_bits = ^redirect_pc[1:0];
`endif

   assign imem_req_valid = (state == REQ);
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid & imem_req_ready;
   assign if_opcode      = if_instr[6:0];

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         pc          <= RESET_PC[XLEN-1:0];
         kill        <= 1'b0;
         inflight_pc <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         kill  <= kill_nxt;
         if (req_fire) begin
            inflight_pc <= pc;
         end
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         misalign <= 1'b0;
      end else begin
         misalign <= misalign_nxt;
      end
   end
`endif

   // ---------------------------------------------------------------------
   // Next state / control
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      kill_nxt  = kill;
      load_mem  = 1'b0;
      load_buf  = 1'b0;
      bubble    = 1'b0;
      buf_load  = 1'b0;
      buf_clear = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_nxt = misalign;
`endif

      case (state)
         IDLE: begin
            // A request may still be outstanding if fetch was halted while
            // waiting; its response must drain before a new request issues.
            if (kill && imem_rsp_valid) begin
               kill_nxt = 1'b0;
            end
            if (!stuck && (!kill || imem_rsp_valid)) begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (req_fire) begin
               state_nxt = WAIT;
               pc_nxt    = pc + XLEN'(4);
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               state_nxt = REQ;
               if (kill) begin
                  kill_nxt = 1'b0;
               end else if (stall) begin
                  buf_load  = 1'b1;
                  state_nxt = HOLD;
               end else begin
                  load_mem = 1'b1;
               end
            end
         end
         HOLD: begin
            if (!stall) begin
               load_buf  = 1'b1;
               buf_clear = 1'b1;
               state_nxt = REQ;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Redirect overrides everything except reset, including stall.
      if (redirect_valid) begin
         pc_nxt    = redirect_tgt;
         bubble    = 1'b1;
         load_mem  = 1'b0;
         load_buf  = 1'b0;
         buf_load  = 1'b0;
         buf_clear = 1'b1;
         case (state)
            REQ:     if (req_fire) kill_nxt = 1'b1;
            WAIT:    if (!imem_rsp_valid) kill_nxt = 1'b1;
            HOLD:    state_nxt = REQ;
            default: ;
         endcase
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_nxt = redirect_bad;
         if (redirect_bad) begin
            state_nxt = IDLE;
         end
`endif
      end
   end

   // ---------------------------------------------------------------------
   // IF/ID output register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         if_valid <= 1'b0;
         if_pc    <= '0;
         if_instr <= NOP_INSTR;
      end else if (bubble) begin
         if_valid <= 1'b0;
         if_instr <= NOP_INSTR;
      end else if (load_mem) begin
         if_valid <= 1'b1;
         if_pc    <= inflight_pc;
         if_instr <= imem_rsp_data;
      end else if (load_buf) begin
         if_valid <= buf_valid;
         if_pc    <= buf_pc;
         if_instr <= buf_instr;
      end else if (!stall) begin
         // decode consumed the current entry; present it only once
         if_valid <= 1'b0;
      end
   end

   fetch_skid_buf #(
      .XLEN      (XLEN),
      .NOP_INSTR (NOP_INSTR)
   ) u_skid (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (buf_load),
      .clear    (buf_clear),
      .in_pc    (inflight_pc),
      .in_instr (imem_rsp_data),
      .valid    (buf_valid),
      .pc       (buf_pc),
      .instr    (buf_instr)
   );

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit. A bench-side
//                instruction memory answers requests with random latency;
//                a stream model tracks the next PC to be requested and the
//                next PC decode must receive, and every cycle is checked.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

   localparam logic [63:0] RST_PC = 64'h0;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic        stall, redirect_valid, if_valid;
   logic [63:0] imem_req_addr, redirect_pc, if_pc;
   logic [31:0] imem_rsp_data, if_instr;
   logic [6:0]  if_opcode;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        fetch_misalign;
`endif

   instr_fetch_unit #(
      .XLEN      (64),
      .RESET_PC  (RST_PC),
      .NOP_INSTR (NOP)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .if_opcode      (if_opcode)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .fetch_misalign (fetch_misalign)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Instruction memory contents: a few fixed words, otherwise an
   // address-derived pattern with a rotating set of real opcodes.
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      logic [6:0] op;
      case (a[4:2])
         3'd0: op = 7'b0110011;
         3'd1: op = 7'b0000011;
         3'd2: op = 7'b0010011;
         3'd3: op = 7'b0100011;
         3'd4: op = 7'b1100011;
         3'd5: op = 7'b1100111;
         3'd6: op = 7'b1101111;
         default: op = 7'b0010011;
      endcase
      case (a)
         64'h0:   return 32'h0000_0033;
         64'h4:   return 32'h00A0_0093;
         64'hC:   return 32'hDEAD_BEEF;
         64'h104: return 32'h0000_006F;
         default: return {a[31:7] ^ a[56:32] ^ 25'h15A_5A5A, op};
      endcase
   endfunction

   // memory and model state
   logic [63:0] pend_addr[$];
   int          pend_due[$];
   int          lat_min = 1;
   int          lat_max = 1;
   int          edge_n  = 0;
   logic [63:0] exp_req = RST_PC;   // next address the fetch unit must request
   logic [63:0] exp_del = RST_PC;   // next PC decode must receive
   logic        stuck   = 1'b0;
   int          deliveries = 0;

   // outputs sampled at the previous falling edge
   logic        s_req_valid = 1'b0, s_if_valid = 1'b0;
   logic [63:0] s_req_addr = '0, s_if_pc = '0;
   logic [31:0] s_if_instr = '0;
   logic [6:0]  s_if_opcode = '0;

   // One clock: apply the current inputs, then check what the edge did.
   task automatic tick();
      logic        pr_n, pready, prsp, pstall, predir;
      logic [63:0] prpc, tgt;
      logic [31:0] w;
      pr_n   = reset_n;
      pready = imem_req_ready;
      prsp   = imem_rsp_valid;
      pstall = stall;
      predir = redirect_valid;
      prpc   = redirect_pc;
      @(posedge clk);
      edge_n++;
      @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
      tgt = prpc;
`else
      tgt = {prpc[63:2], 2'b00};
`endif
      if (!pr_n) begin
         pend_addr.delete();
         pend_due.delete();
         exp_req = RST_PC;
         exp_del = RST_PC;
         stuck   = 1'b0;
         chk("rst_if_valid", if_valid, 1'b0);
         chk("rst_if_instr", if_instr, NOP);
         chk("rst_req_valid", imem_req_valid, 1'b0);
         chk("rst_req_addr", imem_req_addr, RST_PC);
      end else begin
         if (prsp && pend_addr.size() > 0) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end
         // an entry shown while decode is not stalled and not flushed is consumed
         if (s_if_valid && !pstall && !predir) begin
            w = mem_word(exp_del);
            chk("del_pc", s_if_pc, exp_del);
            chk("del_instr", s_if_instr, w);
            chk("del_opcode", s_if_opcode, w[6:0]);
            deliveries++;
            exp_del = exp_del + 64'd4;
         end
         if (s_req_valid && pready) begin
            chk("req_addr", s_req_addr, exp_req);
            chk("one_outstanding", 64'(pend_addr.size()), 64'd0);
            pend_addr.push_back(s_req_addr);
            pend_due.push_back(edge_n + int'($urandom_range(lat_max, lat_min)));
            exp_req = exp_req + 64'd4;
         end else if (s_req_valid && !predir) begin
            chk("req_hold_valid", imem_req_valid, 1'b1);
            chk("req_hold_addr", imem_req_addr, s_req_addr);
         end
         if (predir) begin
            exp_req = tgt;
            exp_del = tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
            stuck = (prpc[1:0] != 2'b00);
            chk("misalign_flag", fetch_misalign, stuck);
`endif
            chk("redir_if_valid", if_valid, 1'b0);
            chk("redir_if_instr", if_instr, NOP);
         end else if (pstall) begin
            chk("stall_if_valid", if_valid, s_if_valid);
            chk("stall_if_pc", if_pc, s_if_pc);
            chk("stall_if_instr", if_instr, s_if_instr);
         end
         if (stuck) begin
            chk("stuck_no_req", imem_req_valid, 1'b0);
         end
      end
      s_req_valid = imem_req_valid;
      s_req_addr  = imem_req_addr;
      s_if_valid  = if_valid;
      s_if_pc     = if_pc;
      s_if_instr  = if_instr;
      s_if_opcode = if_opcode;
      // memory response for the coming edge
      if (pend_addr.size() > 0 && pend_due[0] <= edge_n + 1) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(pend_addr[0]);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
   endtask

   task automatic wait_req();
      int n = 0;
      while (!s_req_valid && n < 40) begin
         tick();
         n++;
      end
      if (n >= 40) chk("timeout_req", 64'(s_req_valid), 64'd1);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!s_if_valid && n < 40) begin
         tick();
         n++;
      end
      if (n >= 40) chk("timeout_if_valid", 64'(s_if_valid), 64'd1);
   endtask

   initial begin
      logic [63:0] rp;
      int          del_start;
      reset_n        = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      @(negedge clk);
      tick();
      tick();
      chk("reset_if_valid", if_valid, 1'b0);
      chk("reset_if_instr", if_instr, 32'h0000_0013);
      chk("reset_if_opcode", if_opcode, 7'h13);
      chk("reset_req_valid", imem_req_valid, 1'b0);
      chk("reset_req_addr", imem_req_addr, 64'h0);

      // straight-line fetch with a 1-cycle memory
      reset_n        = 1'b1;
      imem_req_ready = 1'b1;
      wait_req();
      chk("first_req_addr", s_req_addr, 64'h0);
      wait_valid();
      chk("first_pc", s_if_pc, 64'h0);
      chk("first_opcode", s_if_opcode, 7'b0110011);
      tick();
      wait_valid();
      chk("second_pc", s_if_pc, 64'h4);
      chk("second_opcode", s_if_opcode, 7'b0010011);

      // memory not ready for three cycles on addr 8
      imem_req_ready = 1'b0;
      chk("notready_valid", s_req_valid, 1'b1);
      chk("notready_addr", s_req_addr, 64'h8);
      repeat (3) begin
         tick();
         chk("notready_hold_valid", imem_req_valid, 1'b1);
         chk("notready_hold_addr", imem_req_addr, 64'h8);
      end
      imem_req_ready = 1'b1;
      tick();
      wait_req();
      chk("after_ready_addr", s_req_addr, 64'hC);

      // redirect while waiting on 0xC; stale response arrives 2 cycles later
      lat_min = 3;
      lat_max = 3;
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h100;
      tick();
      redirect_valid = 1'b0;
      lat_min = 1;
      lat_max = 1;
      tick();
      tick();
      chk("stale_dropped", if_valid, 1'b0);
      wait_req();
      chk("redir_req_addr", s_req_addr, 64'h100);
      wait_valid();
      chk("redir_first_pc", s_if_pc, 64'h100);

      // stall across the 0x104 response
      stall = 1'b1;
      repeat (6) begin
         tick();
         chk("stall_hold_pc", if_pc, 64'h100);
         chk("stall_hold_valid", if_valid, 1'b1);
      end
      stall = 1'b0;
      tick();
      chk("unstall_pc", if_pc, 64'h104);
      chk("unstall_instr", if_instr, 32'h0000_006F);
      chk("unstall_valid", if_valid, 1'b1);

      // reset asserted with a request outstanding
      lat_min = 3;
      lat_max = 3;
      tick();
      reset_n = 1'b0;
      tick();
      chk("midreset_if_valid", if_valid, 1'b0);
      chk("midreset_if_instr", if_instr, 32'h0000_0013);
      chk("midreset_req_valid", imem_req_valid, 1'b0);
      tick();
      reset_n = 1'b1;
      lat_min = 1;
      lat_max = 1;
      wait_req();
      chk("postreset_req_addr", s_req_addr, 64'h0);

      // randomized traffic
      lat_min   = 1;
      lat_max   = 4;
      del_start = deliveries;
      for (int i = 0; i < 3000; i++) begin
         imem_req_ready = ($urandom_range(9, 0) < 7);
         stall          = ($urandom_range(9, 0) < 3);
         redirect_valid = ($urandom_range(99, 0) < 4);
         rp = {$urandom, $urandom};
         if ($urandom_range(7, 0) == 0) rp = 64'hFFFF_FFFF_FFFF_FFF0 | (rp & 64'hF);
         else                           rp = rp & 64'hFFF;
`ifdef FETCH_MISALIGN_TRAP_EN
         rp[1:0] = 2'b00;
`endif
         redirect_pc = rp;
         tick();
      end
      imem_req_ready = 1'b1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      repeat (20) tick();
      chk("liveness", 64'((deliveries - del_start) >= 150), 64'd1);

`ifdef FETCH_MISALIGN_TRAP_EN
      redirect_valid = 1'b1;
      redirect_pc    = 64'h102;
      tick();
      redirect_valid = 1'b0;
      chk("misalign_set", fetch_misalign, 1'b1);
      repeat (8) begin
         tick();
         chk("misalign_no_req", imem_req_valid, 1'b0);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 64'h200;
      tick();
      redirect_valid = 1'b0;
      chk("misalign_clear", fetch_misalign, 1'b0);
      wait_req();
      chk("misalign_resume_addr", s_req_addr, 64'h200);
      repeat (10) tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
